// File: rtl/udp_perf_pkg.sv
// Shared types and helpers for the UDP loopback performance checker.
// Lane pattern geometry, checker FSM encoding and counter saturation.
package udp_perf_pkg;

    localparam int SEQ_W  = 16;
    localparam int IDX_W  = 16;
    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_DROP = 2'd3
    } chk_state_e;

    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input int          w
    );
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/axis_keep_check.sv
// Combinational tkeep qualifier: byte popcount, all-ones and
// contiguous-from-bit-0 flags.
module axis_keep_check #(
    parameter int KEEP_WIDTH = 64,
    parameter int PC_W       = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [PC_W-1:0]       pop_cnt,
    output logic                  all_ones,
    output logic                  contig
);

    logic [KEEP_WIDTH-1:0] keep_inc;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            pop_cnt = pop_cnt + PC_W'(keep[i]);
        end
    end

    // A run of ones from bit 0 turns into a single carry when incremented.
    assign keep_inc = keep + KEEP_WIDTH'(1);
    assign all_ones = &keep;
    assign contig   = keep[0] && ((keep & keep_inc) == '0);

endmodule

// File: rtl/udp_rx_pkt_checker.sv
// RX packet checker for the UDP loopback path: validates length, sequence
// and lane pattern of each packet and keeps saturating statistics.
module udp_rx_pkt_checker
    import udp_perf_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic                  cfg_enable,
    input  logic [15:0]           cfg_pkt_size,
    input  logic                  cfg_clear,
    output logic [CNT_WIDTH-1:0]  recv_pkt_count,
    output logic [CNT_WIDTH-1:0]  err_pkt_count,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic                  cycle_count_full,
    output logic                  first_pkt_seen,
    output logic [15:0]           last_err_seq
);

    localparam int LANES = DATA_WIDTH / LANE_W;
    localparam int PC_W  = $clog2(KEEP_WIDTH + 1);

    chk_state_e           state_q, state_d;
    logic                 rdy_q, in_pkt_q, mid_next;
    logic                 fire, chk, is_head, pkt_done;
    logic [SEQ_W-1:0]     seq_q, exp_seq_q, cur_seq;
    logic                 seq_known_q, seq_err;
    logic [IDX_W-1:0]     idx_q, base;
    logic [15:0]          bytes_q, size_q, cur_size, bytes_new;
    logic [16:0]          sum;
    logic                 sat_q, sat_new, err_q, err_new, pkt_err;
    logic                 lane_err, keep_err;
    logic [PC_W-1:0]      pop_cnt;
    logic                 all_ones, contig;
    logic [CNT_WIDTH-1:0] recv_q, err_cnt_q, beat_q, cyc_q;
    logic                 first_q;
    logic [15:0]          last_err_q;

    axis_keep_check #(
        .KEEP_WIDTH (KEEP_WIDTH),
        .PC_W       (PC_W)
    ) u_keep (
        .keep     (s_axis_tkeep),
        .pop_cnt  (pop_cnt),
        .all_ones (all_ones),
        .contig   (contig)
    );

    assign fire     = s_axis_tvalid & rdy_q;
    assign is_head  = (state_q == ST_HEAD);
    assign chk      = fire & cfg_enable & (is_head | (state_q == ST_BODY));
    assign pkt_done = chk & s_axis_tlast;
    assign mid_next = fire ? ~s_axis_tlast : in_pkt_q;

    assign cur_seq  = is_head ? s_axis_tdata[LANE_W-1:IDX_W] : seq_q;
    assign cur_size = is_head ? cfg_pkt_size : size_q;
    assign base     = is_head ? '0 : idx_q;
    assign sum      = (is_head ? 17'd0 : {1'b0, bytes_q}) + 17'(pop_cnt);
    assign bytes_new = sum[16] ? 16'hFFFF : sum[15:0];
    assign sat_new  = (~is_head & sat_q) | sum[16];

    always_comb begin
        lane_err = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (&s_axis_tkeep[4*k +: 4] &&
                s_axis_tdata[LANE_W*k +: LANE_W] != {cur_seq, base + IDX_W'(k)})
                lane_err = 1'b1;
        end
    end

    assign keep_err = s_axis_tlast ? ~contig : ~all_ones;
    assign seq_err  = is_head & seq_known_q & (cur_seq != exp_seq_q);
    assign err_new  = (~is_head & err_q) | lane_err | keep_err | seq_err;
    assign pkt_err  = err_new | sat_new | (bytes_new != cur_size) |
                      s_axis_tuser[0];

    // The boundary tracker lets a re-enable land cleanly on the next head.
    always_comb begin
        state_d = state_q;
        if (!cfg_enable) begin
            state_d = mid_next ? ST_DROP : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DROP: state_d = mid_next ? ST_DROP : ST_HEAD;
                ST_HEAD, ST_BODY: state_d = mid_next ? ST_BODY : ST_HEAD;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b0;
            in_pkt_q <= 1'b0;
            seq_q    <= '0;
            idx_q    <= '0;
            bytes_q  <= '0;
            size_q   <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (fire) in_pkt_q <= ~s_axis_tlast;
            if (chk) begin
                seq_q   <= cur_seq;
                idx_q   <= base + IDX_W'(LANES);
                bytes_q <= bytes_new;
                size_q  <= cur_size;
                sat_q   <= sat_new;
                err_q   <= err_new;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            recv_q      <= '0;
            err_cnt_q   <= '0;
            beat_q      <= '0;
            cyc_q       <= '0;
            first_q     <= 1'b0;
            last_err_q  <= '0;
            exp_seq_q   <= '0;
            seq_known_q <= 1'b0;
        end else if (cfg_clear) begin
            recv_q      <= '0;
            err_cnt_q   <= '0;
            beat_q      <= '0;
            cyc_q       <= '0;
            first_q     <= 1'b0;
            last_err_q  <= '0;
            exp_seq_q   <= '0;
            seq_known_q <= 1'b0;
        end else begin
            if (fire & cfg_enable)
                beat_q <= CNT_WIDTH'(sat_inc(64'(beat_q), CNT_WIDTH));
            if (chk & is_head)
                first_q <= 1'b1;
            if (cfg_enable & (first_q | (chk & is_head)))
                cyc_q <= CNT_WIDTH'(sat_inc(64'(cyc_q), CNT_WIDTH));
            if (pkt_done) begin
                exp_seq_q   <= cur_seq + 1'b1;
                seq_known_q <= 1'b1;
                if (pkt_err) begin
                    err_cnt_q  <= CNT_WIDTH'(sat_inc(64'(err_cnt_q), CNT_WIDTH));
                    last_err_q <= cur_seq;
                end else begin
                    recv_q <= CNT_WIDTH'(sat_inc(64'(recv_q), CNT_WIDTH));
                end
            end
        end
    end

    assign s_axis_tready    = rdy_q;
    assign recv_pkt_count   = recv_q;
    assign err_pkt_count    = err_cnt_q;
    assign beat_count       = beat_q;
    assign cycle_count      = cyc_q;
    assign cycle_count_full = &cyc_q;
    assign first_pkt_seen   = first_q;
    assign last_err_seq     = last_err_q;

endmodule

// File: tb/tb_udp_rx_pkt_checker.sv
// Directed bench for udp_rx_pkt_checker with narrow counters so that
// saturation is reachable in a short run.
module tb_udp_rx_pkt_checker;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [DW-1:0] tdata = '0;
    logic [KW-1:0] tkeep = '0;
    logic          tlast = 1'b0;
    logic [0:0]    tuser = '0;
    logic          cfg_enable = 1'b0;
    logic [15:0]   cfg_pkt_size = '0;
    logic          cfg_clear = 1'b0;
    logic [CW-1:0] recv_cnt, err_cnt, beat_cnt, cyc_cnt;
    logic          cyc_full, first_seen;
    logic [15:0]   last_err;

    int total = 0;
    int bad = 0;

    int          cor_beat, cor_lane, flip_beat, flip_byte;
    int          off_beat, on_beat, clr_beat;
    logic [31:0] cor_val;

    logic [63:0] k36 = 64'h0000_000F_FFFF_FFFF;
    logic [63:0] k34 = 64'h0000_0003_FFFF_FFFF;
    logic [63:0] kf0 = 64'h0000_0000_0000_00F0;
    logic [63:0] kall = '1;

    always #5 clk = ~clk;

    udp_rx_pkt_checker #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (1),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK              (clk),
        .RST_N            (rst_n),
        .s_axis_tvalid    (tvalid),
        .s_axis_tready    (tready),
        .s_axis_tdata     (tdata),
        .s_axis_tkeep     (tkeep),
        .s_axis_tlast     (tlast),
        .s_axis_tuser     (tuser),
        .cfg_enable       (cfg_enable),
        .cfg_pkt_size     (cfg_pkt_size),
        .cfg_clear        (cfg_clear),
        .recv_pkt_count   (recv_cnt),
        .err_pkt_count    (err_cnt),
        .beat_count       (beat_cnt),
        .cycle_count      (cyc_cnt),
        .cycle_count_full (cyc_full),
        .first_pkt_seen   (first_seen),
        .last_err_seq     (last_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_beat(input logic [15:0] seq,
                                                input int b);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++)
            d[32*k +: 32] = {seq, 16'(16 * b + k)};
        return d;
    endfunction

    task automatic no_faults();
        cor_beat = -1; cor_lane = 0; cor_val = '0;
        flip_beat = -1; flip_byte = 0;
        off_beat = -1; on_beat = -1; clr_beat = -1;
    endtask

    task automatic send_pkt(input logic [15:0] seq, input int nb,
                            input logic [63:0] last_keep, input bit user);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            tvalid = 1'b1;
            tdata  = make_beat(seq, b);
            if (b == cor_beat) tdata[32*cor_lane +: 32] = cor_val;
            if (b == flip_beat) tdata[8*flip_byte +: 8] ^= 8'hFF;
            tlast  = (b == nb - 1);
            tkeep  = tlast ? last_keep : kall;
            tuser  = tlast ? 1'(user) : 1'b0;
            if (b == off_beat) cfg_enable = 1'b0;
            if (b == on_beat) cfg_enable = 1'b1;
            cfg_clear = (b == clr_beat);
            @(posedge clk);
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast = 1'b0;
        cfg_clear = 1'b0;
    endtask

    task automatic clear_stats();
        @(negedge clk);
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
    endtask

    initial begin
        no_faults();
        repeat (2) @(negedge clk);
        check("rst_tready", 32'(tready), 0);
        check("rst_recv", 32'(recv_cnt), 0);
        check("rst_beat", 32'(beat_cnt), 0);
        check("rst_first", 32'(first_seen), 0);
        check("rst_lerr", 32'(last_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_up", 32'(tready), 1);

        // ten clean 256-byte packets
        cfg_enable = 1'b1;
        cfg_pkt_size = 16'd256;
        for (int s = 0; s < 10; s++) send_pkt(16'(s), 4, kall, 1'b0);
        check("s1_recv", 32'(recv_cnt), 10);
        check("s1_err", 32'(err_cnt), 0);
        check("s1_beat", 32'(beat_cnt), 40);
        check("s1_cyc", 32'(cyc_cnt), 49);
        check("s1_first", 32'(first_seen), 1);

        // short last beat: contiguous vs non-contiguous keep
        clear_stats();
        cfg_pkt_size = 16'd100;
        send_pkt(16'd0, 2, k36, 1'b0);
        check("s2_recv", 32'(recv_cnt), 1);
        send_pkt(16'd1, 2, kf0, 1'b0);
        check("s2_err", 32'(err_cnt), 1);
        check("s2_recv2", 32'(recv_cnt), 1);

        // sequence gap
        clear_stats();
        cfg_pkt_size = 16'd256;
        send_pkt(16'd5, 4, kall, 1'b0);
        send_pkt(16'd6, 4, kall, 1'b0);
        send_pkt(16'd8, 4, kall, 1'b0);
        check("s3_err", 32'(err_cnt), 1);
        check("s3_lerr", 32'(last_err), 8);
        send_pkt(16'd9, 4, kall, 1'b0);
        check("s3_recv", 32'(recv_cnt), 3);
        check("s3_err2", 32'(err_cnt), 1);

        // lane corruption, partial lane, tuser, length
        clear_stats();
        cor_beat = 1; cor_lane = 3; cor_val = 32'h0000_0014;
        send_pkt(16'd0, 4, kall, 1'b0);
        no_faults();
        check("s4_lane", 32'(err_cnt), 1);
        cfg_pkt_size = 16'd98;
        flip_beat = 1; flip_byte = 32;
        send_pkt(16'd1, 2, k34, 1'b0);
        no_faults();
        check("s4_part_recv", 32'(recv_cnt), 1);
        check("s4_part_err", 32'(err_cnt), 1);
        send_pkt(16'd2, 2, k34, 1'b1);
        check("s4_user", 32'(err_cnt), 2);
        check("s4_user_lerr", 32'(last_err), 2);
        send_pkt(16'd3, 2, k36, 1'b0);
        check("s4_len", 32'(err_cnt), 3);
        check("s4_len_recv", 32'(recv_cnt), 1);

        // enable drop mid-packet
        clear_stats();
        cfg_pkt_size = 16'd256;
        off_beat = 1; on_beat = 2;
        send_pkt(16'd1, 4, kall, 1'b0);
        no_faults();
        check("s5_recv", 32'(recv_cnt), 0);
        check("s5_err", 32'(err_cnt), 0);
        check("s5_beat", 32'(beat_cnt), 3);
        send_pkt(16'd2, 4, kall, 1'b0);
        check("s5_next_recv", 32'(recv_cnt), 1);
        check("s5_next_err", 32'(err_cnt), 0);
        check("s5_next_beat", 32'(beat_cnt), 7);

        // saturation, then clear coinciding with tlast
        clear_stats();
        for (int s = 0; s < 70; s++) send_pkt(16'(s), 4, kall, 1'b0);
        check("s6_recv", 32'(recv_cnt), 70);
        check("s6_beat_sat", 32'(beat_cnt), 255);
        check("s6_cyc_sat", 32'(cyc_cnt), 255);
        check("s6_full", 32'(cyc_full), 1);
        clr_beat = 3;
        send_pkt(16'd70, 4, kall, 1'b0);
        no_faults();
        check("s6_clr_recv", 32'(recv_cnt), 0);
        check("s6_clr_err", 32'(err_cnt), 0);
        check("s6_clr_beat", 32'(beat_cnt), 0);
        check("s6_clr_cyc", 32'(cyc_cnt), 0);
        check("s6_clr_full", 32'(cyc_full), 0);
        check("s6_clr_first", 32'(first_seen), 0);
        send_pkt(16'd100, 4, kall, 1'b0);
        check("s6_relearn_recv", 32'(recv_cnt), 1);
        check("s6_relearn_err", 32'(err_cnt), 0);
        check("s6_relearn_beat", 32'(beat_cnt), 4);
        check("s6_relearn_cyc", 32'(cyc_cnt), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
